overlay_window_ctrl: RTL and testbench
======================================

// Module: overlay_window_ctrl
// PURPOSE
//  Sequences the 1-bit overlay ROM against the HDMI video timing: tracks raster position,
//  generates ROM read addresses inside a programmable window, delays video/sync to match
//  ROM latency, and mixes the expanded overlay bit with the incoming pixel.
//  Sits between the video timing source and the HDMI TX pixel path.
// PARAMETERS
//  OVL_W    128  overlay width in pixels (ROM row length)
//  OVL_H    32   overlay height in lines
//  ROM_AW   12   ROM address width; OVL_W*OVL_H <= 2**ROM_AW
//  ROM_LAT  2    ROM read latency, rom_addr -> rom_data, in clk cycles (>=1)
//  XY_W     11   raster coordinate width
// PORTS
//  clk        in   1       pixel clock
//  rst_n      in   1       asynchronous active-low reset
//  vs_in      in   1       vsync, active-high
//  hs_in      in   1       hsync, active-high
//  de_in      in   1       data enable, high during active pixels
//  pixel_in   in   24      video pixel {R,G,B}
//  ovl_x      in   XY_W    window left column; sampled on vs_in rising edge
//  ovl_y      in   XY_W    window top line; sampled on vs_in rising edge
//  ovl_en     in   1       overlay enable; sampled on vs_in rising edge
//  rom_addr   out  ROM_AW  ROM read address
//  rom_rd     out  1       ROM read strobe, high for in-window pixels
//  rom_data   in   1       ROM bit, valid ROM_LAT cycles after rom_rd
//  vs_out     out  1       vs_in delayed by LAT
//  hs_out     out  1       hs_in delayed by LAT
//  de_out     out  1       de_in delayed by LAT
//  pixel_out  out  24      mixed pixel
//  frame_done out  1       1-cycle pulse after last overlay pixel of a frame is read
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state IDLE, delay lines cleared.
//  - LAT = ROM_LAT+1 cycles, fixed, input to every output (vs/hs/de/pixel aligned).
//  - x counter: increments per de_in=1 cycle, clears on de_in falling edge. y counter:
//    increments on de_in falling edge, clears on vs_in rising edge.
//  - FSM: IDLE -> (vs_in rise) ARMED: latch ovl_x/ovl_y/ovl_en, row_base=0.
//    ARMED -> (first de_in=1) ACTIVE. ACTIVE -> (y reaches ovl_y+OVL_H, or vs_in rise) DONE;
//    DONE: frame_done pulses once, -> ARMED on next vs_in rise (relatch). vs_in rise in
//    any state relatches and enters ARMED; frame_done not issued for aborted frames.
//  - In-window: de_in & x in [ovl_x, ovl_x+OVL_W) & y in [ovl_y, ovl_y+OVL_H) & ovl_en latched.
//    rom_rd = in-window; rom_addr = row_base + (x-ovl_x), truncated to ROM_AW.
//    row_base += OVL_W on de_in falling edge of any line with y in window range.
//  - Clipping: window past right/bottom of active area simply yields fewer reads; row
//    alignment kept by row_base. ovl_x+OVL_W computed at XY_W+1 bits, no wrap.
//  - Mix (at output stage, window flag delayed LAT): rom_data=1 -> 24'hFFFFFF;
//    rom_data=0 -> see CONFIGURATION; outside window -> pixel_in delayed. de_out=0 -> pixel_out=0.
//  - ovl_x/ovl_y/ovl_en changes mid-frame ignored until next vs_in rising edge.
//  - Reset mid-frame: outputs drop to 0 at once; overlay resumes only after next vs_in rise.
// CONFIGURATION
//  OVL_TRANSPARENCY_EN defined: in-window rom_data=0 -> each channel of delayed pixel
//   shifted right 1 (50% darkened background box).
//  Not defined: in-window rom_data=0 -> delayed pixel passed unchanged.
// STRUCTURE
//  Package ovl_pkg: FSM state enum (IDLE, ARMED, ACTIVE, DONE), PIX_W=24,
//  OVL_WHITE=24'hFFFFFF, window-compare helper function.
//  Sub-module ovl_delay_line (parameterised width/depth shift register, async clear)
//  used for the 27-bit {vs,hs,de,pixel} bundle and the window flag.
// TESTING
//  1. 640x480 timing, ovl_x=10, ovl_y=5, ovl_en=1: line 5 px10 -> rom_addr 0, px137 -> 127,
//     line 6 px10 -> 128; 4096 reads per frame; frame_done once after line 36.
//  2. ROM model all-ones, ROM_LAT=2: window pixels FFFFFF exactly 3 cycles after input;
//     outside window pixel_out == pixel_in delayed 3; vs/hs/de_out aligned.
//  3. ROM all-zeros, pixel_in=24'h80C040: macro on -> 24'h406020; macro off -> 24'h80C040.
//  4. ovl_x=600 (clipped at 640): 40 reads/line, line 6 starts at rom_addr 128.
//  5. Change ovl_x mid-frame: current frame unaffected; new position from next vs_in rise.
//  6. rst_n low mid-window for 3 cycles: outputs 0 immediately; no rom_rd until next
//     vs_in rise; next frame addresses restart at 0; ovl_en=0 frame -> zero rom_rd.

Source files
------------

// File: rtl/ovl_pkg.sv
// Shared types, constants and the window-compare helper for the overlay window controller.
package ovl_pkg;
  localparam int PIX_W = 24;
  localparam logic [PIX_W-1:0] OVL_WHITE = 24'hFFFFFF;
  localparam int SPAN_W = 16;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} ovl_state_e;

  // lo <= v < lo+len, with the upper bound carried one bit wider so a window
  // hanging past the raster edge never wraps back into range.
  function automatic logic in_span(input logic [SPAN_W-1:0] v,
                                   input logic [SPAN_W-1:0] lo,
                                   input logic [SPAN_W-1:0] len);
    logic [SPAN_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (v >= lo) && ({1'b0, v} < hi);
  endfunction
endpackage

// File: rtl/ovl_delay_line.sv
// Fixed-depth shift register with asynchronous clear, used to line video and
// window flag up with the ROM read latency.
module ovl_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/overlay_window_ctrl.sv
// Overlay window controller: raster tracking, windowed ROM addressing and latency-matched mix.
// Define OVL_TRANSPARENCY_EN to halve the background behind clear overlay bits.
//
// state  | meaning
// IDLE   | no window configuration latched since reset
// ARMED  | config latched on vsync rise, waiting for first active pixel
// ACTIVE | frame in progress, window rows being read
// DONE   | last window row finished, frame_done issued; wait for next vsync
module overlay_window_ctrl import ovl_pkg::*; #(
  parameter int OVL_W   = 128,
  parameter int OVL_H   = 32,
  parameter int ROM_AW  = 12,
  parameter int ROM_LAT = 2,
  parameter int XY_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [XY_W-1:0]   ovl_x,
  input  logic [XY_W-1:0]   ovl_y,
  input  logic              ovl_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rd,
  input  logic              rom_data,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              frame_done
);
  localparam int BUS_W = PIX_W + 3;

  ovl_state_e        state_q, state_d;
  logic              vs_prev_q, de_prev_q;
  logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
  logic [XY_W-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic              en_q, en_d;
  logic [ROM_AW-1:0] row_base_q, row_base_d;
  logic              frame_done_q, frame_done_d;
  logic [BUS_W-1:0]  out_q, out_d;

  logic              vs_rise, de_fall, x_hit, y_hit, y_end, in_win;
  logic [XY_W-1:0]   x_rel;
  logic [BUS_W-1:0]  bus_dly;
  logic              win_dly;
  logic [PIX_W-1:0]  pix_mix;

  assign vs_rise = vs_in & ~vs_prev_q;
  assign de_fall = ~de_in & de_prev_q;
  assign x_hit   = in_span(SPAN_W'(x_q), SPAN_W'(ox_q), SPAN_W'(OVL_W));
  assign y_hit   = in_span(SPAN_W'(y_q), SPAN_W'(oy_q), SPAN_W'(OVL_H));
  assign y_end   = ({1'b0, y_q} == ({1'b0, oy_q} + (XY_W+1)'(OVL_H)));
  assign in_win  = de_in & en_q & x_hit & y_hit;
  assign x_rel   = x_q - ox_q;

  assign rom_rd   = in_win;
  assign rom_addr = in_win ? (row_base_q + ROM_AW'(x_rel)) : '0;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    en_d         = en_q;
    row_base_d   = row_base_q;
    frame_done_d = 1'b0;

    if (de_in)        x_d = x_q + XY_W'(1);
    else if (de_fall) x_d = '0;

    if (de_fall) begin
      y_d = y_q + XY_W'(1);
      if (y_hit) row_base_d = row_base_q + ROM_AW'(OVL_W);
    end

    unique case (state_q)
      IDLE:    state_d = IDLE;
      ARMED:   if (de_in) state_d = ACTIVE;
      ACTIVE:  if (y_end) begin
                 state_d      = DONE;
                 frame_done_d = en_q;
               end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // A vsync rise always restarts the frame, aborting any frame still in flight.
    if (vs_rise) begin
      state_d      = ARMED;
      ox_d         = ovl_x;
      oy_d         = ovl_y;
      en_d         = ovl_en;
      row_base_d   = '0;
      y_d          = '0;
      frame_done_d = 1'b0;
    end
  end

  ovl_delay_line #(.W(BUS_W), .DEPTH(ROM_LAT)) u_bus_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({vs_in, hs_in, de_in, pixel_in}),
    .q     (bus_dly)
  );

  ovl_delay_line #(.W(1), .DEPTH(ROM_LAT)) u_win_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_win),
    .q     (win_dly)
  );

  always_comb begin
    pix_mix = bus_dly[PIX_W-1:0];
    if (win_dly && rom_data) pix_mix = OVL_WHITE;
`ifdef OVL_TRANSPARENCY_EN
    else if (win_dly) pix_mix = {1'b0, bus_dly[23:17], 1'b0, bus_dly[15:9], 1'b0, bus_dly[7:1]};
`endif
    if (!bus_dly[PIX_W]) pix_mix = '0;
    out_d = {bus_dly[BUS_W-1:PIX_W], pix_mix};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      en_q         <= 1'b0;
      row_base_q   <= '0;
      frame_done_q <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_in;
      de_prev_q    <= de_in;
      x_q          <= x_d;
      y_q          <= y_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      en_q         <= en_d;
      row_base_q   <= row_base_d;
      frame_done_q <= frame_done_d;
      out_q        <= out_d;
    end
  end

  assign {vs_out, hs_out, de_out, pixel_out} = out_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_overlay_window_ctrl.sv
// Self-checking bench for overlay_window_ctrl: reduced 160x40 raster, ROM model
// with 2-cycle latency, per-cycle comparison against a raster-level model.
module tb_overlay_window_ctrl;
  localparam int OVL_W = 128, OVL_H = 32, ROM_AW = 12, ROM_LAT = 2, XY_W = 11;
  localparam int LAT = ROM_LAT + 1;
  localparam int ACT_W = 160, ACT_H = 40;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0]       pixel_in = '0;
  logic [XY_W-1:0]   ovl_x = '0, ovl_y = '0;
  logic              ovl_en = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_rd;
  logic              rom_data = 1'b0;
  logic              vs_out, hs_out, de_out, frame_done;
  logic [23:0]       pixel_out;

  overlay_window_ctrl #(.OVL_W(OVL_W), .OVL_H(OVL_H), .ROM_AW(ROM_AW),
                        .ROM_LAT(ROM_LAT), .XY_W(XY_W)) dut (
    .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .pixel_in(pixel_in), .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_en(ovl_en),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .pixel_out(pixel_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic              rom_mem [1 << ROM_AW];
  logic [26:0]       exp_h [LAT];
  logic              rd_h [ROM_LAT];
  logic [ROM_AW-1:0] ad_h [ROM_LAT];
  bit lat_valid = 0, len = 0, vs_last = 0, win_lines_done = 0;
  int lox = 0, loy = 0, rst_hold = 0, frame_reads = 0, done_count = 0;
  bit const_pix = 0;
  int pa_n = 0, pa_ln [3], pa_col [3], pa_val [3];
  bit po_on = 0;
  int po_ln = 0, po_col = 0, pin_cnt = 0;
  logic [23:0] po_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] rp();
    if (const_pix) return 24'h80C040;
    return 24'($urandom) & 24'hFFFFFE;
  endfunction

  // One pixel clock: drive inputs, evaluate the model, check at the falling edge.
  task automatic cyc(input logic vs, input logic hs, input logic de, input int ln, input int col);
    bit win;
    int addr;
    logic [23:0] pix, po;
    logic [7:0] r, g, b;
    logic [26:0] cur;
    pix = rp();
    win = 0;
    addr = 0;
    rst_n = (rst_hold == 0);
    if (rst_hold > 0) rst_hold--;
    vs_in = vs; hs_in = hs; de_in = de; pixel_in = pix;
    if (!rst_n) begin
      lat_valid = 0;
      for (int i = 0; i < LAT; i++) exp_h[i] = '0;
    end else if (vs && !vs_last) begin
      lat_valid = 1; lox = int'(ovl_x); loy = int'(ovl_y); len = ovl_en;
    end
    vs_last = rst_n ? vs : 1'b0;
    if (rst_n && lat_valid && len && de && col >= lox && col < lox + OVL_W &&
        ln >= loy && ln < loy + OVL_H) begin
      win = 1;
      addr = ((ln - loy) * OVL_W + (col - lox)) % (1 << ROM_AW);
    end
    po = pix;
    if (win) begin
      r = pix[23:16]; g = pix[15:8]; b = pix[7:0];
      if (rom_mem[addr]) po = 24'hFFFFFF;
`ifdef OVL_TRANSPARENCY_EN
      else po = {r / 8'd2, g / 8'd2, b / 8'd2};
`else
      else po = {r, g, b};
`endif
    end
    if (!de) po = '0;
    cur = rst_n ? {vs, hs, de, po} : 27'd0;
    if (po_on && ln == po_ln && col == po_col) pin_cnt = LAT + 1;

    @(negedge clk);
    chk("rom_rd", rom_rd, win);
    if (win) chk("rom_addr", rom_addr, addr);
    for (int i = 0; i < pa_n; i++)
      if (ln == pa_ln[i] && col == pa_col[i]) chk("pin_rom_addr", rom_addr, pa_val[i]);
    chk("video_out", {vs_out, hs_out, de_out, pixel_out}, exp_h[LAT-1]);
    if (!win_lines_done) chk("frame_done_early", frame_done, 0);
    if (pin_cnt > 0) begin
      pin_cnt--;
      if (pin_cnt == 0) chk("pin_pixel_out", pixel_out, po_val);
    end
    if (rom_rd) frame_reads++;
    if (frame_done) done_count++;

    rom_data = rd_h[ROM_LAT-1] ? rom_mem[ad_h[ROM_LAT-1]] : 1'b0;
    for (int i = ROM_LAT - 1; i > 0; i--) begin rd_h[i] = rd_h[i-1]; ad_h[i] = ad_h[i-1]; end
    rd_h[0] = rom_rd; ad_h[0] = rom_addr;
    for (int i = LAT - 1; i > 0; i--) exp_h[i] = exp_h[i-1];
    exp_h[0] = cur;
    @(posedge clk); #1;
  endtask

  // mode: 0 random ROM, 1 all ones, 2 all zeros with constant pixel 80C040
  task automatic run_frame(input int ox, input int oy, input bit en, input int mode,
                           input int rst_ln, input int rst_col, input int exp_reads);
    int done_exp;
    for (int a = 0; a < (1 << ROM_AW); a++)
      rom_mem[a] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    const_pix = (mode == 2);
    ovl_x = XY_W'(ox); ovl_y = XY_W'(oy); ovl_en = en;
    frame_reads = 0; done_count = 0; win_lines_done = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, -1, -1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, -1, -1);
    for (int ln = 0; ln < ACT_H; ln++) begin
      if (ln == 10) begin
        ovl_x = XY_W'($urandom); ovl_y = XY_W'($urandom); ovl_en = 1'($urandom);
      end
      for (int i = 0; i < 2; i++) cyc(0, 1, 0, ln, -1);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, ln, -1);
      for (int col = 0; col < ACT_W; col++) begin
        if (ln == rst_ln && col == rst_col) rst_hold = 3;
        cyc(0, 0, 1, ln, col);
      end
      if (ln == loy + OVL_H - 1) win_lines_done = 1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, ln, -1);
    end
    for (int i = 0; i < ACT_W + 6; i++) cyc(0, 0, 0, -1, -1);
    done_exp = (lat_valid && len && loy + OVL_H <= ACT_H) ? 1 : 0;
    chk("frame_done_count", done_count, done_exp);
    if (exp_reads >= 0) chk("frame_read_count", frame_reads, exp_reads);
    pa_n = 0; po_on = 0;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) exp_h[i] = '0;
    for (int i = 0; i < ROM_LAT; i++) begin rd_h[i] = 1'b0; ad_h[i] = '0; end
    for (int a = 0; a < (1 << ROM_AW); a++) rom_mem[a] = 1'b0;
    @(posedge clk); #1;
    rst_hold = 4;
    cyc(0, 0, 0, -1, -1);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_pixel_out", pixel_out, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, -1, -1);

    // Basic window, pinned addresses and full 4096-read frame
    pa_n = 3;
    pa_ln[0] = 5; pa_col[0] = 10;  pa_val[0] = 0;
    pa_ln[1] = 5; pa_col[1] = 137; pa_val[1] = 127;
    pa_ln[2] = 6; pa_col[2] = 10;  pa_val[2] = 128;
    run_frame(10, 5, 1, 0, -1, -1, 4096);

    // All-ones ROM: white exactly LAT cycles after the input pixel
    po_on = 1; po_ln = 5; po_col = 10; po_val = 24'hFFFFFF;
    run_frame(10, 5, 1, 1, -1, -1, 4096);

    // All-zeros ROM with constant background
    po_on = 1; po_ln = 6; po_col = 20;
`ifdef OVL_TRANSPARENCY_EN
    po_val = 24'h406020;
`else
    po_val = 24'h80C040;
`endif
    run_frame(10, 5, 1, 2, -1, -1, 4096);

    // Right-edge clipping: 40 reads per line, next row still starts at 128
    pa_n = 2;
    pa_ln[0] = 4; pa_col[0] = 120; pa_val[0] = 128;
    pa_ln[1] = 3; pa_col[1] = 159; pa_val[1] = 39;
    run_frame(120, 3, 1, 0, -1, -1, 1280);

    run_frame(30, 8, 1, 0, -1, -1, 4096);

    // Reset mid-window at line 10 column 40: 6 full rows + 20 pixels read beforehand
    run_frame(20, 4, 1, 0, 10, 40, 788);

    pa_n = 1; pa_ln[0] = 4; pa_col[0] = 20; pa_val[0] = 0;
    run_frame(20, 4, 1, 0, -1, -1, 4096);

    run_frame(20, 4, 0, 0, -1, -1, 0);

    // Bottom clipping: frame aborted by next vsync, no frame_done
    run_frame(int'($urandom_range(0, 140)), 20, 1, 0, -1, -1, -1);

    run_frame(int'($urandom_range(0, 32)), int'($urandom_range(0, 8)), 1, 0, -1, -1, 4096);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
